// File: rtl/avalon_mem_master.sv
// CPU load/store front end for an Avalon-MM data-memory slave: one request at a time,
// word-aligned bus cycles with lane enables, extended load data, misalign/timeout errors.
module avalon_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_error,
  output logic [31:0] cpu_rdata,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] writedata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic          signed_q;

  logic          misaligned;
  logic [3:0]    be_req;
  logic [31:0]   wd_req;
  logic [31:0]   lane;
  logic [31:0]   load_val;

  // Request decode: lane enables, replicated store data and the alignment check.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    misaligned = 1'b0;
    be_req     = 4'b0000;
    wd_req     = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        be_req = 4'b0001 << cpu_addr[1:0];
        wd_req = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = cpu_addr[0];
        be_req     = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wd_req     = {2{cpu_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |cpu_addr[1:0];
        be_req     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Right-justify the addressed lane of readdata, then extend it.
  always_comb begin
    lane     = readdata >> {off_q, 3'b000};
    load_val = lane;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{16{signed_q & lane[15]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      signed_q   <= 1'b0;
      cpu_busy   <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_error  <= 1'b0;
      cpu_rdata  <= '0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            size_q   <= cpu_size;
            off_q    <= cpu_addr[1:0];
            signed_q <= cpu_signed;
            wait_cnt <= '0;
            cpu_busy <= 1'b1;
            if (misaligned) begin
              state     <= DONE;
              cpu_done  <= 1'b1;
              cpu_error <= 1'b1;
            end else begin
              state      <= ACCESS;
              address    <= {cpu_addr[31:2], 2'b00};
              byteenable <= be_req;
              writedata  <= wd_req;
              read       <= ~cpu_write;
              write      <= cpu_write;
            end
          end
        end
        ACCESS: begin
          if (!waitrequest) begin
            if (read) cpu_rdata <= load_val;
            read     <= 1'b0;
            write    <= 1'b0;
            state    <= DONE;
            cpu_done <= 1'b1;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // This edge is the TIMEOUT_CYCLES-th stalled one: abort without touching cpu_rdata.
            read      <= 1'b0;
            write     <= 1'b0;
            state     <= DONE;
            cpu_done  <= 1'b1;
            cpu_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          cpu_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mem_master.sv
// Scoreboard bench for avalon_mem_master: byte-level reference memory, a behavioural
// Avalon slave with programmable wait states, and decoupled bus/completion monitors.
module tb_avalon_mem_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_write = 1'b0, cpu_signed = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_busy, cpu_done, cpu_error;
  logic [31:0] cpu_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        read, write;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  avalon_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_error(cpu_error), .cpu_rdata(cpu_rdata), .address(address),
    .byteenable(byteenable), .read(read), .write(write),
    .waitrequest(waitrequest), .readdata(readdata), .writedata(writedata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } done_exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  done_exp_t done_q[$];
  bus_exp_t  bus_q[$];
  int        n_checks = 0;
  int        n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and the last completed load value.
  bit [7:0]    ref_mem[bit [31:0]];
  logic [31:0] ref_rdata = '0;

  // Behavioural slave: word memory, stall starts on the rising edge of read/write.
  bit [31:0] slv_mem[bit [29:0]];
  int        slv_waits = 0;
  bit        slv_stall = 1'b0;
  bit        active = 1'b0;
  bit        committed = 1'b0;
  int        wl = 0;

  always begin
    @(posedge clk);
    #1;
    if (read || write) begin
      if (!active) begin
        active    = 1'b1;
        wl        = slv_waits;
        committed = 1'b0;
      end else if (wl > 0) begin
        wl--;
      end
      if (slv_stall || wl > 0) begin
        waitrequest = 1'b1;
        readdata    = $urandom;
      end else begin
        waitrequest = 1'b0;
        if (!committed) begin
          bit [31:0] w;
          committed = 1'b1;
          w = slv_mem.exists(address[31:2]) ? slv_mem[address[31:2]] : 32'h0;
          if (write) begin
            for (int i = 0; i < 4; i++)
              if (byteenable[i]) w[8*i +: 8] = writedata[8*i +: 8];
            slv_mem[address[31:2]] = w;
          end else begin
            readdata = w;
          end
        end
      end
    end else begin
      active      = 1'b0;
      waitrequest = 1'b0;
      readdata    = $urandom;
    end
  end

  // Bus monitor: pops one expected transfer per rising read/write, checks it is held.
  bit          prev_rw = 1'b0;
  bit          prev_done = 1'b0;
  int          n_bus = 0;
  logic        obs_wr;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_be;

  always @(negedge clk) begin
    if (reset) begin
      prev_rw   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (read || write) begin
        check("rw_exclusive", read & write, 0);
        if (!prev_rw) begin
          n_bus++;
          obs_wr = write; obs_addr = address; obs_be = byteenable; obs_wd = writedata;
          check("bus_expected", bus_q.size() != 0, 1);
          if (bus_q.size() != 0) begin
            bus_exp_t e;
            e = bus_q.pop_front();
            check("bus_write", write, e.wr);
            check("bus_address", address, e.addr);
            check("bus_byteenable", byteenable, e.be);
            if (e.wr) check("bus_writedata", writedata, e.wdata);
          end
        end else begin
          check("hold_address", address, obs_addr);
          check("hold_byteenable", byteenable, obs_be);
          check("hold_writedata", writedata, obs_wd);
          check("hold_write", write, obs_wr);
        end
      end
      prev_rw = read || write;

      if (cpu_done) begin
        check("done_single_cycle", prev_done, 0);
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_error", cpu_error, d.err);
          check("done_rdata", cpu_rdata, d.rdata);
        end
      end else if (cpu_error) begin
        check("error_without_done", cpu_error, 0);
      end
      prev_done = cpu_done;
    end
  end

  // Issue one request: push the expected bus transfer and completion, then pulse cpu_req.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input bit sgn, input logic [31:0] wd, input bit timeout,
                       output bit illegal);
    done_exp_t   d;
    bus_exp_t    b;
    int          nb;
    logic [31:0] v, mask;
    @(negedge clk);
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    illegal = (size == 2'd3) || ((addr % nb) != 0);
    d.err   = 1'b1;
    d.rdata = ref_rdata;
    if (!illegal) begin
      b.wr    = wr;
      b.addr  = addr & ~32'h3;
      b.be    = '0;
      for (int k = 0; k < nb; k++) b.be[int'(addr[1:0]) + k] = 1'b1;
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = 8'(wd >> (8 * (i % nb)));
      bus_q.push_back(b);
      if (!timeout) begin
        d.err = 1'b0;
        if (wr) begin
          for (int k = 0; k < nb; k++) ref_mem[addr + k] = 8'(wd >> (8 * k));
        end else begin
          v = '0;
          for (int k = 0; k < nb; k++)
            v = v | (32'(ref_mem.exists(addr + k) ? ref_mem[addr + k] : 8'h0) << (8 * k));
          mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
          if (sgn && v[8*nb-1]) v = v | ~mask;
          ref_rdata = v;
          d.rdata   = v;
        end
      end
    end
    done_q.push_back(d);
    cpu_write = wr; cpu_addr = addr; cpu_size = size; cpu_signed = sgn; cpu_wdata = wd;
    cpu_req = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_done && cyc < budget);
    check({name, "_done_seen"}, cpu_done, 1);
  endtask

  // Full transaction with completion-latency check (request edge to cpu_done).
  task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                        input logic [1:0] size, input bit sgn, input logic [31:0] wd);
    bit ill;
    int cyc;
    issue(wr, addr, size, sgn, wd, 1'b0, ill);
    wait_done(name, 50, cyc);
    check({name, "_latency"}, cyc, ill ? 1 : 2 + slv_waits);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {cpu_busy, cpu_done, cpu_error, read, write}, 0);
    check({name, "_address"}, address, 0);
    check({name, "_byteenable"}, byteenable, 0);
    check({name, "_writedata"}, writedata, 0);
    check({name, "_cpu_rdata"}, cpu_rdata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ill;
    int cyc, cnt, bus0, dones;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Word store then load with 4 wait states.
    slv_waits = 4;
    do_txn("word_store", 1'b1, 32'hBFC0_0010, 2'd2, 1'b0, 32'hDEAD_BEEF);
    check("word_store_be", obs_be, 4'b1111);
    do_txn("word_load", 1'b0, 32'hBFC0_0010, 2'd2, 1'b0, 32'h0);
    check("word_load_value", cpu_rdata, 32'hDEAD_BEEF);

    // Byte loads, signed and unsigned.
    do_txn("word_store2", 1'b1, 32'hBFC0_0010, 2'd2, 1'b0, 32'h80FF_7F01);
    do_txn("byte_signed", 1'b0, 32'hBFC0_0013, 2'd0, 1'b1, 32'h0);
    check("byte_signed_be", obs_be, 4'b1000);
    check("byte_signed_value", cpu_rdata, 32'hFFFF_FF80);
    do_txn("byte_unsigned", 1'b0, 32'hBFC0_0013, 2'd0, 1'b0, 32'h0);
    check("byte_unsigned_value", cpu_rdata, 32'h0000_0080);
    do_txn("byte_off1", 1'b0, 32'hBFC0_0011, 2'd0, 1'b0, 32'h0);
    check("byte_off1_value", cpu_rdata, 32'h0000_007F);

    // Half store to upper half.
    do_txn("half_store", 1'b1, 32'hBFC0_0012, 2'd1, 1'b0, 32'h1234_ABCD);
    check("half_store_addr", obs_addr, 32'hBFC0_0010);
    check("half_store_be", obs_be, 4'b1100);
    check("half_store_wd", obs_wd, 32'hABCD_ABCD);

    // Misaligned word load: done/error right after the sampling edge, no bus cycle.
    bus0 = n_bus;
    issue(1'b0, 32'hBFC0_0011, 2'd2, 1'b0, 32'h0, 1'b0, ill);
    @(negedge clk);
    check("misaligned_done", {cpu_done, cpu_error}, 2'b11);
    check("misaligned_rw", {read, write}, 2'b00);
    check("misaligned_rdata_kept", cpu_rdata, 32'h0000_007F);
    @(negedge clk);
    check("misaligned_done_drop", cpu_done, 0);
    check("misaligned_no_bus", n_bus, bus0);

    // Zero-wait cycle timing.
    slv_waits = 0;
    issue(1'b0, 32'hBFC0_0010, 2'd1, 1'b1, 32'h0, 1'b0, ill);
    @(negedge clk);
    check("zw_read_high", {read, cpu_done}, 2'b10);
    @(negedge clk);
    check("zw_done", {read, cpu_done}, 2'b01);
    @(negedge clk);
    check("zw_idle", {read, cpu_busy, cpu_done}, 3'b000);

    // Timeout: slave stalls forever.
    slv_stall = 1'b1;
    issue(1'b0, 32'hBFC0_0014, 2'd2, 1'b0, 32'h0, 1'b1, ill);
    cnt = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (read && waitrequest) cnt++;
    end while (!cpu_done && cyc < 40);
    check("timeout_read_edges", cnt, TO);
    check("timeout_done_error", {cpu_done, cpu_error, read}, 3'b110);
    @(negedge clk);
    check("timeout_busy_low", {cpu_busy, cpu_done}, 2'b00);

    // Asynchronous reset two cycles into a stalled read.
    issue(1'b0, 32'hBFC0_0018, 2'd2, 1'b0, 32'h0, 1'b1, ill);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_read", read, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    done_q.delete();
    bus_q.delete();
    ref_rdata = '0;
    slv_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_done) dones++;
    end
    check("reset_no_done", dones, 0);

    // Request pulsed during ACCESS is ignored.
    slv_waits = 4;
    bus0 = n_bus;
    issue(1'b0, 32'hBFC0_0010, 2'd2, 1'b0, 32'h0, 1'b0, ill);
    @(negedge clk);
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 32'hBFC0_0020; cpu_wdata = 32'h5555_AAAA;
    @(negedge clk);
    cpu_req = 1'b0;
    wait_done("gated", 50, cyc);
    repeat (8) @(negedge clk);
    check("gated_one_transfer", n_bus - bus0, 1);
    check("gated_idle", cpu_busy, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      slv_waits = $urandom_range(0, 5);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_txn("rand", 1'($urandom_range(0, 1)), 32'hBFC0_0040 + 32'($urandom_range(0, 31)),
             sz, 1'($urandom_range(0, 1)), $urandom);
    end

    repeat (4) @(negedge clk);
    check("done_queue_drained", done_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_mem_master.md
# avalon_mem_master

Memory-access front end between the CPU datapath and the Avalon-MM data-memory slave. Accepts one load/store request at a time with byte, half or word size. Converts it into a single word-aligned Avalon read or write with the correct byteenable and lane-replicated writedata, and holds the request until `waitrequest` drops. Returns right-justified, sign- or zero-extended load data, and reports misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, 64: number of consecutive `waitrequest`-high cycles in ACCESS that aborts a transfer; must be ≥1.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: start request; sampled only in IDLE.
- `cpu_write` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `cpu_signed` in 1: 1 = sign-extend load data.
- `cpu_wdata` in 32: store data, right-justified.
- `cpu_busy` out 1: high whenever state ≠ IDLE.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_error` out 1: one-cycle pulse alongside `cpu_done` on misalignment or timeout.
- `cpu_rdata` out 32: extended load data; valid while `cpu_done` is high, held until the next completion.
- `address` out 32: Avalon word address, `{cpu_addr[31:2],2'b00}`.
- `byteenable` out 4: Avalon lane enables.
- `read` out 1: Avalon read.
- `write` out 1: Avalon write.
- `waitrequest` in 1: Avalon stall.
- `readdata` in 32: Avalon read data.
- `writedata` out 32: Avalon write data.

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- **IDLE** with `cpu_req`=1:
  - Latch addr, size, signed and write.
  - Alignment check. Half requires `addr[0]`=0. Word requires `addr[1:0]`=0. Size 11 is always illegal.
  - If illegal: go to DONE with the error flag set. No bus cycle is issued and `cpu_rdata` is unchanged.
  - Otherwise: go to ACCESS, driving `address`, `byteenable`, `read` or `write`, and `writedata`. Clear the wait counter.
- **Lanes** (little-endian): byte at offset n uses bits [8n+7:8n].
  - byteenable: byte = 1<<n; half = 0011 (offset 0) or 1100 (offset 2); word = 1111.
  - writedata: byte replicated ×4; half replicated ×2; word unchanged.
- **ACCESS**:
  - `read` or `write` is held constant together with `address`, `byteenable` and `writedata`.
  - At an edge where `waitrequest`=0: the transfer completes. For a load, extract the lane from `readdata` and extend it to 32 bits per `cpu_signed` into `cpu_rdata`. Then go to DONE and deassert `read`/`write`.
  - At an edge where `waitrequest`=1: increment the counter. When the counter reaches `TIMEOUT_CYCLES`, deassert `read`/`write`, set the error flag and go to DONE without updating `cpu_rdata`.
- **DONE**: `cpu_done`=1, and `cpu_error`=error flag. `read`/`write` are low. Go to IDLE unconditionally. `cpu_req` is ignored.
- `cpu_req` is ignored while busy. There is no queueing.

## Timing
- Reset values: state IDLE, counter 0. `cpu_busy`, `cpu_done`, `cpu_error`, `read` and `write` are 0. `address`, `byteenable`, `writedata` and `cpu_rdata` are 0.
- Reset asserted mid-ACCESS: `read`/`write` drop immediately (asynchronously). No `cpu_done` is produced.
- Request sampled at edge E0:
  - `read`/`write` rise in the cycle after E0.
  - With zero wait states, completion is at E1 and `cpu_done` is high between E1 and E2.
  - Each wait cycle adds one cycle of latency.
- Misaligned request at E0: `cpu_done`=`cpu_error`=1 between E0 and E1. `read`/`write` never assert.
- Timeout: `read` is high for exactly `TIMEOUT_CYCLES` edges with `waitrequest`=1. `cpu_done` and `cpu_error` are high in the following cycle.
- `read`/`write` are low for at least 2 cycles between back-to-back transfers (DONE then IDLE). The slave starts its stall on the rising edge of `read`/`write`, so every transfer must present a fresh rising edge.
- `read` and `write` are never high simultaneously.

## Test plan
- **Word store then load**:
  - Stimulus: word write 0xDEADBEEF to 0xBFC00010, then word read of the same address, against the RAM slave (4 wait cycles).
  - Required: byteenable 1111, `write` held until `waitrequest` falls, one `cpu_done` per request, `cpu_rdata`=0xDEADBEEF.
- **Byte load, signed and unsigned**:
  - Stimulus: memory word 0x80FF7F01 at 0xBFC00010; signed byte load at 0xBFC00013, then unsigned byte load at the same address.
  - Required: byteenable 1000; signed gives 0xFFFFFF80; unsigned gives 0x00000080. A byte load at offset 1 gives 0x0000007F.
- **Half store**:
  - Stimulus: half store 0x1234ABCD at 0xBFC00012.
  - Required: `address`=0xBFC00010, byteenable 1100, `writedata`=0xABCDABCD.
- **Misaligned word load**:
  - Stimulus: word load at 0xBFC00011.
  - Required: `read` stays 0; `cpu_done`=`cpu_error`=1 for one cycle after the sampling edge; `cpu_rdata` unchanged.
- **Timeout**:
  - Stimulus: `TIMEOUT_CYCLES`=8, slave holds `waitrequest`=1.
  - Required: `read` high for 8 edges, then low; `cpu_done`=`cpu_error`=1 the next cycle; `cpu_busy` low after it.
- **Reset and request gating**:
  - Stimulus: assert `reset` two cycles into a read; separately, pulse `cpu_req` during ACCESS.
  - Required: `read` drops without waiting for a clock edge, no `cpu_done`, all outputs 0. A second request pulsed during ACCESS is ignored, with no second transfer.
